fp_add_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined single-precision adder (`u_add`) among `N_REQ` requesters, such as the neuron/accumulator units of the forward and back-propagation datapath. It accepts operand pairs over a valid/ready handshake and issues at most one pair per cycle to the adder. It tracks each in-flight operation with a fixed-latency tag pipe and returns every sum tagged with its requester ID.

---
 rtl/fp_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/fp_add_arbiter.sv | 107 ++++++++++
 tb/tb_fp_add_arbiter.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared definitions for the floating-point adder arbiter.
//   FP_W        : operand/sum width (IEEE-754 single precision)
//   FP_ZERO     : value driven onto the adder inputs when nothing issues
//   DEF_ADD_LAT : default adder pipeline depth
//   MAX_ID_W    : widest requester ID (up to 8 requesters)
//   id_width()  : requester-ID width for a given requester count
//   tag_t       : one tag-pipe stage {valid, id}
package fp_arb_pkg;

    localparam int unsigned FP_W        = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam int unsigned DEF_ADD_LAT = 3;
    localparam int unsigned MAX_ID_W    = 3;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Sized for the largest supported requester count; narrower
    // configurations leave the upper id bits at zero.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with its own priority pointer.
//   clk, rst    : clock and synchronous active-high reset
//   req         : per-requester request
//   grant       : one-hot grant (all zero while rst is high)
//   grant_id    : encoded index of the granted requester
//   grant_valid : a grant is being given this cycle
// Every grant is a transfer (grant only goes to an asserted request),
// so the pointer advances past the winner whenever grant_valid is high.
module rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned ID_W = id_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   idx;

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = '0;
        // Search upward from ptr with wrap-around; first hit wins.
        for (int unsigned k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(N)) begin
                idx = idx - (ID_W + 1)'(N);
            end
            if (!grant_valid && req[idx[ID_W-1:0]]) begin
                grant_valid              = 1'b1;
                grant[idx[ID_W-1:0]]     = 1'b1;
                grant_id                 = idx[ID_W-1:0];
            end
        end
        if (rst) begin
            grant       = '0;
            grant_valid = 1'b0;
        end

        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined single-precision adder among N_REQ requesters.
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : per-requester operand-pair valid
//   req_a/b    : packed operands, requester i at [32i+31:32i]
//   req_ready  : one-hot grant, combinational from req_valid and pointer
//   add_a/b    : registered operands to the adder (zero when idle)
//   add_q      : adder sum, ADD_LAT edges after add_a/add_b
//   rsp_valid  : rsp_q holds a sum this cycle
//   rsp_id     : requester owning rsp_q
//   rsp_q      : sum, passed straight through from add_q
//   busy       : any operation in flight
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADD_LAT = DEF_ADD_LAT,
    localparam int unsigned ID_W   = id_width(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*FP_W-1:0] req_a,
    input  logic [N_REQ*FP_W-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [FP_W-1:0]       add_a,
    output logic [FP_W-1:0]       add_b,
    input  logic [FP_W-1:0]       add_q,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [FP_W-1:0]       rsp_q,
    output logic                  busy
);

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             xfer;

    logic [FP_W-1:0] add_a_q, add_a_d;
    logic [FP_W-1:0] add_b_q, add_b_d;

    // Stage 0 is loaded on the issue edge together with add_a/add_b; the
    // remaining ADD_LAT stages track the adder pipeline, so the tail lines
    // up with add_q.
    tag_t tag_q [ADD_LAT+1];
    tag_t tag_d [ADD_LAT+1];

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (xfer)
    );

    assign req_ready = grant;

    always_comb begin
        add_a_d = FP_ZERO;
        add_b_d = FP_ZERO;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                add_a_d = req_a[i*FP_W +: FP_W];
                add_b_d = req_b[i*FP_W +: FP_W];
            end
        end
    end

    always_comb begin
        // id is zeroed with valid so an idle stage is all-zero.
        tag_d[0].valid = xfer;
        tag_d[0].id    = xfer ? MAX_ID_W'(grant_id) : '0;
        for (int unsigned s = 1; s <= ADD_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_a_q <= FP_ZERO;
            add_b_q <= FP_ZERO;
            for (int unsigned s = 0; s <= ADD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s <= ADD_LAT; s++) begin
            busy = busy | (|tag_q[s]);
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = tag_q[ADD_LAT].valid;
    assign rsp_id    = tag_q[ADD_LAT].id[ID_W-1:0];
    assign rsp_q     = add_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed scenarios plus randomized traffic,
// all checked against a scoreboard model that runs alongside.
module tb_fp_add_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [127:0]  req_a = '0;
    logic [127:0]  req_b = '0;
    logic [3:0]    req_ready;
    logic [31:0]   add_a, add_b;
    logic [31:0]   add_q = '0;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_q;
    logic          busy;

    fp_add_arbiter #(
        .N_REQ   (N),
        .ADD_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_q     (add_q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- float helpers (normal numbers only) ----------------
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'(120 + $urandom_range(14)), r[22:0]};
    endfunction

    // Stand-in for u_add: sum appears LAT edges after add_a/add_b.
    logic [31:0] p0 = '0, p1 = '0;
    always @(posedge clk) begin
        p0    <= fadd(add_a, add_b);
        p1    <= p0;
        add_q <= p1;
    end

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        int          id;
        logic [31:0] sum;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          mon_en  = 1'b0;
    int          mptr    = 0;
    logic [31:0] exp_a   = '0;
    logic [31:0] exp_b   = '0;
    int          mg;
    logic [3:0]  mer;
    bit          mev;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (add_a !== exp_a || add_b !== exp_b) begin
                n_fail++;
                $display("FAIL mon_operands: add_a=%h add_b=%h required %h %h",
                         add_a, add_b, exp_a, exp_b);
            end
            mev = (sb.size() > 0) && (sb[0].due == cyc);
            n_tests++;
            if (rsp_valid !== mev) begin
                n_fail++;
                $display("FAIL mon_rsp_valid: got %b required %b (cycle %0d)", rsp_valid, mev, cyc);
            end
            if (mev) begin
                n_tests++;
                if (rsp_id !== 2'(sb[0].id) || rsp_q !== sb[0].sum) begin
                    n_fail++;
                    $display("FAIL mon_rsp_data: id=%0d q=%h required id=%0d q=%h",
                             rsp_id, rsp_q, sb[0].id, sb[0].sum);
                end
                void'(sb.pop_front());
            end
            n_tests++;
            if (busy !== (mev || sb.size() > 0)) begin
                n_fail++;
                $display("FAIL mon_busy: got %b required %b", busy, (mev || sb.size() > 0));
            end
            // Round-robin: first valid requester at or after the pointer.
            mg = -1;
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    if (mg < 0 && req_valid[(mptr + k) % N]) mg = (mptr + k) % N;
                end
            end
            mer = (mg >= 0) ? 4'(1 << mg) : 4'b0000;
            n_tests++;
            if (req_ready !== mer) begin
                n_fail++;
                $display("FAIL mon_grant: req_ready=%b required %b", req_ready, mer);
            end
            if (rst) begin
                sb.delete();
                mptr  = 0;
                exp_a = '0;
                exp_b = '0;
            end else if (mg >= 0) begin
                sb.push_back('{mg, fadd(req_a[mg*32 +: 32], req_b[mg*32 +: 32]), cyc + 4});
                mptr  = (mg + 1) % N;
                exp_a = req_a[mg*32 +: 32];
                exp_b = req_b[mg*32 +: 32];
            end else begin
                exp_a = '0;
                exp_b = '0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = v;
        req_a[i*32 +: 32]  = a;
        req_b[i*32 +: 32]  = b;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = 4'b1111;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0000 || add_a !== 32'h0 || add_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b add_a=%h add_b=%h required 0000 0 0",
                     req_ready, add_a, add_b);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: rsp_valid=%b rsp_id=%0d busy=%b required 0 0 0",
                     rsp_valid, rsp_id, busy);
        end
        mon_en = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_latency();
        tick();
        set_req(1, 1'b1, 32'h3F80_0000, 32'h3F80_0000);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_grant: req_ready=%b required 0010", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (add_a !== 32'h3F80_0000 || add_b !== 32'h3F80_0000) begin
            n_fail++;
            $display("FAIL single_issue: add_a=%h add_b=%h required 3f800000", add_a, add_b);
        end
        for (int k = 2; k <= 4; k++) begin
            tick();
            @(negedge clk);
            n_tests++;
            if (k < 4) begin
                if (rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_early_rsp: rsp_valid=%b at +%0d required 0", rsp_valid, k);
                end
            end else if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_q !== 32'h4000_0000) begin
                n_fail++;
                $display("FAIL single_rsp: valid=%b id=%0d q=%h required 1 1 40000000",
                         rsp_valid, rsp_id, rsp_q);
            end
        end
    endtask

    task automatic test_full_rotation();
        tick();
        req_valid = '0;
        set_req(3, 1'b1, rand_fp(), rand_fp());
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rot_preset: req_ready=%b required 1000", req_ready);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) begin
                for (int i = 0; i < N; i++) set_req(i, 1'b1, rand_fp(), rand_fp());
            end else if (k < 8) begin
                set_req((k - 1) % N, 1'b1, rand_fp(), rand_fp());
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (k < 8) begin
                n_tests++;
                if (req_ready !== 4'(1 << (k % N))) begin
                    n_fail++;
                    $display("FAIL rot_grant: k=%0d req_ready=%b required %b",
                             k, req_ready, 4'(1 << (k % N)));
                end
            end
            if (k >= 4) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 4) % N)) begin
                    n_fail++;
                    $display("FAIL rot_rsp: k=%0d valid=%b id=%0d required 1 %0d",
                             k, rsp_valid, rsp_id, (k - 4) % N);
                end
            end
        end
    endtask

    task automatic test_ptr_skip_wrap();
        logic [3:0] want [4];
        want[0] = 4'b0100; want[1] = 4'b0001; want[2] = 4'b0100; want[3] = 4'b0001;
        tick();
        req_valid = '0;
        set_req(2, 1'b1, rand_fp(), rand_fp());
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                set_req(0, 1'b1, rand_fp(), rand_fp());
                set_req(2, 1'b1, rand_fp(), rand_fp());
            end else if (k > 1) begin
                set_req((k == 2) ? 0 : 2, 1'b1, rand_fp(), rand_fp());
            end
            @(negedge clk);
            n_tests++;
            if (req_ready !== want[k]) begin
                n_fail++;
                $display("FAIL skip_wrap: step %0d req_ready=%b required %b", k, req_ready, want[k]);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_req2_pair();
        set_req(2, 1'b1, 32'h3F00_0000, 32'h3E80_0000);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL pair_grant: req_ready=%b required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (add_a !== 32'h3F00_0000 || add_b !== 32'h3E80_0000) begin
            n_fail++;
            $display("FAIL pair_issue: add_a=%h add_b=%h required 3f000000 3e800000", add_a, add_b);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (add_a !== 32'h0 || add_b !== 32'h0) begin
            n_fail++;
            $display("FAIL pair_idle_zero: add_a=%h add_b=%h required 0 0", add_a, add_b);
        end
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_q !== 32'h3F40_0000) begin
            n_fail++;
            $display("FAIL pair_rsp: valid=%b id=%0d q=%h required 1 2 3f400000",
                     rsp_valid, rsp_id, rsp_q);
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 3; k++) begin
            tick();
            set_req(0, 1'b1, rand_fp(), rand_fp());
            @(negedge clk);
            n_tests++;
            if (req_ready !== 4'b0001) begin
                n_fail++;
                $display("FAIL mid_issue: k=%0d req_ready=%b required 0001", k, req_ready);
            end
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, rand_fp(), rand_fp());
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_rst_ready: req_ready=%b required 0000", req_ready);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_after_rst: busy=%b req_ready=%b required 0 0001", busy, req_ready);
        end
        for (int k = 5; k <= 8; k++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            n_tests++;
            if (k < 8 && rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_discard: k=%0d rsp_valid=%b required 0", k, rsp_valid);
            end else if (k == 8 && (rsp_valid !== 1'b1 || rsp_id !== 2'd0)) begin
                n_fail++;
                $display("FAIL mid_new_rsp: valid=%b id=%0d required 1 0", rsp_valid, rsp_id);
            end
        end
    endtask

    task automatic test_withdrawn();
        logic [3:0] want [4];
        int n_rsp;
        int n_id3;
        want[0] = 4'b1000; want[1] = 4'b0001; want[2] = 4'b0000; want[3] = 4'b0010;
        n_rsp = 0;
        n_id3 = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            req_valid = '0;
            if (k == 0) set_req(3, 1'b1, rand_fp(), rand_fp());
            if (k == 1) begin
                set_req(0, 1'b1, rand_fp(), rand_fp());
                set_req(3, 1'b1, rand_fp(), rand_fp());
            end
            if (k == 3) begin
                set_req(0, 1'b1, rand_fp(), rand_fp());
                set_req(1, 1'b1, rand_fp(), rand_fp());
            end
            @(negedge clk);
            if (k < 4) begin
                n_tests++;
                if (req_ready !== want[k]) begin
                    n_fail++;
                    $display("FAIL withdraw_grant: step %0d req_ready=%b required %b",
                             k, req_ready, want[k]);
                end
            end
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                if (rsp_id === 2'd3) n_id3++;
            end
        end
        n_tests++;
        if (n_rsp != 3 || n_id3 != 1) begin
            n_fail++;
            $display("FAIL withdraw_rsp_count: total=%0d id3=%0d required 3 1", n_rsp, n_id3);
        end
    endtask

    task automatic test_random();
        logic [3:0] gr;
        @(negedge clk);
        gr = req_ready;
        for (int c = 0; c < 400; c++) begin
            tick();
            rst = ($urandom_range(99) == 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !gr[i]) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else begin
                    set_req(i, ($urandom_range(2) != 0), rand_fp(), rand_fp());
                end
            end
            @(negedge clk);
            gr = req_ready;
        end
        tick();
        rst       = 1'b0;
        req_valid = '0;
        repeat (8) tick();
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_full_rotation();
        test_ptr_skip_wrap();
        test_req2_pair();
        test_reset_midflight();
        test_withdrawn();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
